// File: rtl/softreg_cfg_sequencer_if.sv
// Softreg request/response bus: the config sequencer is the master, the accelerator the slave.
interface softreg_cfg_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic              softreg_req_valid;
    logic              softreg_req_isWrite;
    logic [ADDR_W-1:0] softreg_req_addr;
    logic [DATA_W-1:0] softreg_req_data;
    logic              softreg_resp_valid;
    logic [DATA_W-1:0] softreg_resp_data;

    modport master (
        output softreg_req_valid, softreg_req_isWrite, softreg_req_addr, softreg_req_data,
        input  softreg_resp_valid, softreg_resp_data
    );

    modport slave (
        input  softreg_req_valid, softreg_req_isWrite, softreg_req_addr, softreg_req_data,
        output softreg_resp_valid, softreg_resp_data
    );
endinterface

// File: rtl/softreg_cfg_sequencer.sv
// Issues a host-loaded table of softreg writes, then polls a status register until bit0 or timeout.
// Optional SEQ_CYCLE_COUNT_EN adds a saturating busy-cycle counter on elapsed_cycles_o.
module softreg_cfg_sequencer #(
    parameter int NUM_CFG       = 8,
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 64,
    parameter int POLL_INTERVAL = 1024,
    parameter int MAX_POLLS     = 512,
    parameter int IDX_W         = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              tbl_wr_en_i,
    input  logic [IDX_W-1:0]  tbl_wr_idx_i,
    input  logic [ADDR_W-1:0] tbl_wr_addr_i,
    input  logic [DATA_W-1:0] tbl_wr_data_i,
    input  logic [IDX_W:0]    num_cfg_i,
    input  logic [ADDR_W-1:0] poll_addr_i,
    input  logic              start_i,
    softreg_cfg_sequencer_if.master sr_if,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              timeout_o,
    output logic [DATA_W-1:0] result_data_o,
    output logic [15:0]       poll_count_o,
    output logic [31:0]       elapsed_cycles_o
);

    localparam int CNT_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(POLL_INTERVAL - 1);
    localparam logic [IDX_W:0]   NCFG_MAX  = (IDX_W + 1)'(NUM_CFG);
    localparam logic [15:0]      MAX_POLLS_L = 16'(MAX_POLLS);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_WAIT, S_POLL_REQ, S_POLL_RESP, S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [IDX_W:0]    idx_q, idx_d;
    logic [IDX_W:0]    ncfg_q, ncfg_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       poll_cnt_q, poll_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              req_valid_q, req_valid_d;
    logic              req_wr_q, req_wr_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_data_q, req_data_d;

    logic [ADDR_W-1:0] tbl_addr_q [NUM_CFG];
    logic [DATA_W-1:0] tbl_data_q [NUM_CFG];

    logic              idle_like;
    logic              start_ok;
    logic              tbl_we;
    logic              fail_poll;
    logic [IDX_W:0]    ncfg_clamped;

    assign idle_like    = (state_q == S_IDLE) || (state_q == S_DONE);
    assign start_ok     = start_i && idle_like;
    assign tbl_we       = tbl_wr_en_i && idle_like && ({1'b0, tbl_wr_idx_i} < NCFG_MAX);
    assign ncfg_clamped = (num_cfg_i > NCFG_MAX) ? NCFG_MAX : num_cfg_i;

    // Table storage is deliberately not reset; only the host load defines it.
    always_ff @(posedge clk_i) begin
        if (tbl_we) begin
            tbl_addr_q[tbl_wr_idx_i] <= tbl_wr_addr_i;
            tbl_data_q[tbl_wr_idx_i] <= tbl_wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            ncfg_q      <= '0;
            paddr_q     <= '0;
            cnt_q       <= '0;
            poll_cnt_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            result_q    <= '0;
            req_valid_q <= 1'b0;
            req_wr_q    <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ncfg_q      <= ncfg_d;
            paddr_q     <= paddr_d;
            cnt_q       <= cnt_d;
            poll_cnt_q  <= poll_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
            result_q    <= result_d;
            req_valid_q <= req_valid_d;
            req_wr_q    <= req_wr_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
        end
    end

    // Requests are registered one cycle ahead: the transition that enters a request
    // cycle also loads the bus registers, so the bus is driven straight from flops.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ncfg_d      = ncfg_q;
        paddr_d     = paddr_q;
        cnt_d       = cnt_q;
        poll_cnt_d  = poll_cnt_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        result_d    = result_q;
        req_valid_d = 1'b0;
        req_wr_d    = 1'b0;
        req_addr_d  = '0;
        req_data_d  = '0;
        fail_poll   = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    ncfg_d     = ncfg_clamped;
                    paddr_d    = poll_addr_i;
                    poll_cnt_d = '0;
                    result_d   = '0;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    timeout_d  = 1'b0;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                    idx_d      = (IDX_W + 1)'(1);
                    if (ncfg_clamped == '0) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d     = S_WRITE;
                        req_valid_d = 1'b1;
                        req_wr_d    = 1'b1;
                        req_addr_d  = tbl_addr_q[0];
                        req_data_d  = tbl_data_q[0];
                    end
                end
            end
            S_WRITE: begin
                if (idx_q == ncfg_q) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    req_valid_d = 1'b1;
                    req_wr_d    = 1'b1;
                    req_addr_d  = tbl_addr_q[idx_q[IDX_W-1:0]];
                    req_data_d  = tbl_data_q[idx_q[IDX_W-1:0]];
                    idx_d       = idx_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d     = S_POLL_REQ;
                    req_valid_d = 1'b1;
                    req_addr_d  = paddr_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_POLL_REQ: begin
                poll_cnt_d = (poll_cnt_q == 16'hFFFF) ? poll_cnt_q : poll_cnt_q + 16'd1;
                cnt_d      = '0;
                state_d    = S_POLL_RESP;
            end
            S_POLL_RESP: begin
                if (sr_if.softreg_resp_valid) begin
                    result_d = sr_if.softreg_resp_data;
                    if (sr_if.softreg_resp_data[0]) begin
                        state_d = S_DONE;
                        pass_d  = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        fail_poll = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    fail_poll = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (fail_poll) begin
                    if (poll_cnt_q >= MAX_POLLS_L) begin
                        state_d   = S_DONE;
                        timeout_d = 1'b1;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign sr_if.softreg_req_valid   = req_valid_q;
    assign sr_if.softreg_req_isWrite = req_wr_q;
    assign sr_if.softreg_req_addr    = req_addr_q;
    assign sr_if.softreg_req_data    = req_data_q;

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign pass_o        = pass_q;
    assign timeout_o     = timeout_q;
    assign result_data_o = result_q;
    assign poll_count_o  = poll_cnt_q;

`ifdef SEQ_CYCLE_COUNT_EN
    logic [31:0] elapsed_q, elapsed_d;

    always_comb begin
        elapsed_d = elapsed_q;
        if (start_ok) begin
            elapsed_d = '0;
        end else if (busy_q && (elapsed_q != 32'hFFFF_FFFF)) begin
            elapsed_d = elapsed_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            elapsed_q <= '0;
        end else begin
            elapsed_q <= elapsed_d;
        end
    end

    assign elapsed_cycles_o = elapsed_q;
`else
    assign elapsed_cycles_o = '0;
`endif

endmodule

// File: tb/tb_softreg_cfg_sequencer.sv
// Directed bench for softreg_cfg_sequencer: table-driven scenarios plus reset and restart sequences.
module tb_softreg_cfg_sequencer;

    localparam int NUM_CFG = 8;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 64;
    localparam int PI      = 4;
    localparam int MAXP    = 3;
    localparam int IDX_W   = 3;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              tbl_wr_en_i = 1'b0;
    logic [IDX_W-1:0]  tbl_wr_idx_i = '0;
    logic [ADDR_W-1:0] tbl_wr_addr_i = '0;
    logic [DATA_W-1:0] tbl_wr_data_i = '0;
    logic [IDX_W:0]    num_cfg_i = '0;
    logic [ADDR_W-1:0] poll_addr_i = '0;
    logic              start_i = 1'b0;
    logic              busy_o, done_o, pass_o, timeout_o;
    logic [DATA_W-1:0] result_data_o;
    logic [15:0]       poll_count_o;
    logic [31:0]       elapsed_cycles_o;

    softreg_cfg_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) sr ();

    softreg_cfg_sequencer #(
        .NUM_CFG(NUM_CFG), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .POLL_INTERVAL(PI), .MAX_POLLS(MAXP), .IDX_W(IDX_W)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .tbl_wr_en_i(tbl_wr_en_i), .tbl_wr_idx_i(tbl_wr_idx_i),
        .tbl_wr_addr_i(tbl_wr_addr_i), .tbl_wr_data_i(tbl_wr_data_i),
        .num_cfg_i(num_cfg_i), .poll_addr_i(poll_addr_i), .start_i(start_i),
        .sr_if(sr.master),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
        .result_data_o(result_data_o), .poll_count_o(poll_count_o),
        .elapsed_cycles_o(elapsed_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
    } tvec_t;

    // One scenario: inputs, responder behaviour, and hand-computed results.
    typedef struct {
        int          num;
        logic [31:0] paddr;
        logic [63:0] r0, r1, r2;
        int          dly;
        bit          silent;
        bit          xstart;
        bit          busy_wr;
        int          e_writes;
        int          e_first;
        bit          e_pass;
        bit          e_to;
        int          e_pc;
        logic [63:0] e_res;
        int          e_busy;
    } scn_t;

    tvec_t tv [NUM_CFG];
    scn_t  sc [5];
    int    checks = 0;
    int    failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load_table();
        for (int i = 0; i < NUM_CFG; i++) begin
            tbl_wr_en_i   = 1'b1;
            tbl_wr_idx_i  = IDX_W'(i);
            tbl_wr_addr_i = tv[i].addr;
            tbl_wr_data_i = tv[i].data;
            step();
        end
        tbl_wr_en_i = 1'b0;
    endtask

    task automatic run_scn(input int n, input scn_t s);
        int c, wcnt, pcnt, resp_at, bcnt, idle_bad;
        logic [31:0] exp_el;
        num_cfg_i   = (IDX_W + 1)'(s.num);
        poll_addr_i = s.paddr;
        start_i     = 1'b1;
        step();
        start_i = 1'b0;
        c = 1; wcnt = 0; pcnt = 0; resp_at = -1; bcnt = 0; idle_bad = 0;
        check($sformatf("s%0d_busy_c1", n), 64'(busy_o), 64'h1);
        check($sformatf("s%0d_cleared_c1", n),
              64'({done_o, pass_o, timeout_o, poll_count_o}) | result_data_o, 64'h0);
        while (!done_o && c < 200) begin
            if (busy_o) bcnt++;
            if (sr.softreg_req_valid && sr.softreg_req_isWrite) begin
                check($sformatf("s%0d_wr%0d_cycle", n, wcnt), 64'(c), 64'(wcnt + 1));
                if (wcnt < NUM_CFG) begin
                    check($sformatf("s%0d_wr%0d_addr", n, wcnt), 64'(sr.softreg_req_addr), 64'(tv[wcnt].addr));
                    check($sformatf("s%0d_wr%0d_data", n, wcnt), sr.softreg_req_data, tv[wcnt].data);
                end
                wcnt++;
            end else if (sr.softreg_req_valid) begin
                if (pcnt == 0) check($sformatf("s%0d_first_poll", n), 64'(c), 64'(s.e_first));
                if (sr.softreg_req_addr !== s.paddr || sr.softreg_req_data !== 64'h0) idle_bad++;
                if (!s.silent) resp_at = c + 1 + s.dly;
                pcnt++;
            end else if (sr.softreg_req_isWrite || sr.softreg_req_addr != '0 || sr.softreg_req_data != '0) begin
                idle_bad++;
            end
            sr.softreg_resp_valid = 1'b0;
            sr.softreg_resp_data  = '0;
            if (c == resp_at) begin
                sr.softreg_resp_valid = 1'b1;
                sr.softreg_resp_data  = (pcnt == 1) ? s.r0 : (pcnt == 2) ? s.r1 : s.r2;
            end
            start_i     = (c == 3) && s.xstart;
            tbl_wr_en_i = (c == 4) && s.busy_wr;
            tbl_wr_idx_i  = 3'd5;
            tbl_wr_addr_i = 32'hDEAD_BEEF;
            tbl_wr_data_i = 64'hFFFF_FFFF_FFFF_FFFF;
            step();
            c++;
        end
        sr.softreg_resp_valid = 1'b0;
        start_i = 1'b0;
        tbl_wr_en_i = 1'b0;
`ifdef SEQ_CYCLE_COUNT_EN
        exp_el = 32'(s.e_busy);
`else
        exp_el = 32'd0;
`endif
        check($sformatf("s%0d_done", n), 64'(done_o), 64'h1);
        check($sformatf("s%0d_busy_end", n), 64'(busy_o), 64'h0);
        check($sformatf("s%0d_writes", n), 64'(wcnt), 64'(s.e_writes));
        check($sformatf("s%0d_pass", n), 64'(pass_o), 64'(s.e_pass));
        check($sformatf("s%0d_timeout", n), 64'(timeout_o), 64'(s.e_to));
        check($sformatf("s%0d_poll_count", n), 64'(poll_count_o), 64'(s.e_pc));
        check($sformatf("s%0d_result", n), result_data_o, s.e_res);
        check($sformatf("s%0d_busy_cycles", n), 64'(bcnt), 64'(s.e_busy));
        check($sformatf("s%0d_elapsed", n), 64'(elapsed_cycles_o), 64'(exp_el));
        check($sformatf("s%0d_req_bus", n), 64'(idle_bad), 64'h0);
        step();
        step();
        check($sformatf("s%0d_hold", n),
              64'({done_o, pass_o, timeout_o, busy_o}), 64'({1'b1, s.e_pass, s.e_to, 1'b0}));
        check($sformatf("s%0d_elapsed_hold", n), 64'(elapsed_cycles_o), 64'(exp_el));
    endtask

    initial begin
        tv[0] = '{32'd0, 64'd1001};
        tv[1] = '{32'd1, 64'd1001};
        tv[2] = '{32'd2, 64'd0};
        tv[3] = '{32'd3, 64'd16064};
        tv[4] = '{32'd4, 64'd24072};
        tv[5] = '{32'd5, 64'd32080};
        tv[6] = '{32'd6, 64'd10};
        tv[7] = '{32'd7, 64'd0};
        //         num paddr       r0               r1                       r2       dly sil xst bwr wr first pass to pc result                   busy
        sc[0] = '{8,  32'h100, 64'h0,           64'h0,                   64'h1,   1,  0,  1,  1,  8, 13,   1,   0, 3, 64'h1,                   29};
        sc[1] = '{8,  32'h200, 64'h2,           64'h4,                   64'hFE,  0,  0,  0,  0,  8, 13,   0,   1, 3, 64'hFE,                  26};
        sc[2] = '{3,  32'h300, 64'h0,           64'h0,                   64'h0,   0,  1,  0,  0,  3, 8,    0,   1, 3, 64'h0,                   30};
        sc[3] = '{0,  32'h400, 64'hDEAD_0001,   64'h0,                   64'h0,   2,  0,  0,  0,  0, 5,    1,   0, 1, 64'hDEAD_0001,           8};
        sc[4] = '{12, 32'h500, 64'h0,           64'h8000_0000_0000_0003, 64'h0,   0,  0,  0,  0,  8, 13,   1,   0, 2, 64'h8000_0000_0000_0003, 20};

        sr.softreg_resp_valid = 1'b0;
        sr.softreg_resp_data  = '0;

        #1 rst_i = 1'b0;
        #2;
        check("rst_req", 64'({sr.softreg_req_valid, sr.softreg_req_isWrite}), 64'h0);
        check("rst_flags", 64'({busy_o, done_o, pass_o, timeout_o, poll_count_o}), 64'h0);
        check("rst_result", result_data_o, 64'h0);
        check("rst_elapsed", 64'(elapsed_cycles_o), 64'h0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
        step();
        load_table();

        // Reset in the middle of the write burst must clear everything without a clock edge.
        num_cfg_i   = 4'd8;
        poll_addr_i = 32'h100;
        start_i     = 1'b1;
        step();
        start_i = 1'b0;
        step();
        step();
        check("midwr_active", 64'({sr.softreg_req_valid, sr.softreg_req_isWrite, busy_o}), 64'h7);
        #2 rst_i = 1'b0;
        #1;
        check("midwr_rst_req", 64'({sr.softreg_req_valid, sr.softreg_req_isWrite}), 64'h0);
        check("midwr_rst_addr", 64'(sr.softreg_req_addr), 64'h0);
        check("midwr_rst_data", sr.softreg_req_data, 64'h0);
        check("midwr_rst_flags", 64'({busy_o, done_o, pass_o, timeout_o, poll_count_o}), 64'h0);
        check("midwr_rst_elapsed", 64'(elapsed_cycles_o), 64'h0);
        step();
        step();
        rst_i = 1'b1;
        step();
        check("post_rst_idle", 64'({busy_o, done_o, sr.softreg_req_valid}), 64'h0);
        load_table();

        for (int i = 0; i < 5; i++) run_scn(i, sc[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/softreg_cfg_sequencer.md
Name: softreg_cfg_sequencer

Overview:
- Parametrised, synthesizable successor to the fixed softreg stimulus sequence used in simulation tops.
- Issues a host-loaded table of softreg writes (N_VERT, VADDR, WRITE_ADDR0, N_ROUNDS, DONE_READ_PARAMS, etc.), one per cycle.
- Then polls a status register (e.g. DONE_ALL) at a programmable interval until success or timeout.
- Sits between a host/bench controller and the accelerator's softreg request/response port.

Parameters:
- NUM_CFG, 8, depth of the config-write table.
- ADDR_W, 32, softreg address width.
- DATA_W, 64, softreg data width.
- POLL_INTERVAL, 1024, cycles between poll reads; also the per-poll response wait limit.
- MAX_POLLS, 512, failed polls allowed before timeout.
- IDX_W, $clog2(NUM_CFG) (min 1), table index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- tbl_wr_en  in  1  write one table entry.
- tbl_wr_idx  in  IDX_W  entry index.
- tbl_wr_addr  in  ADDR_W  softreg address for entry.
- tbl_wr_data  in  DATA_W  softreg data for entry.
- num_cfg  in  IDX_W+1  entries to issue, 0..NUM_CFG; sampled on start.
- poll_addr  in  ADDR_W  status register address; sampled on start.
- start  in  1  single-cycle start pulse.
- softreg_req_valid  out  1  request strobe.
- softreg_req_isWrite  out  1  1 = write, 0 = read.
- softreg_req_addr  out  ADDR_W  request address.
- softreg_req_data  out  DATA_W  request write data (0 on reads).
- softreg_resp_valid  in  1  read response strobe.
- softreg_resp_data  in  DATA_W  read response data.
- busy  out  1  sequence in progress.
- done  out  1  sequence finished (level).
- pass  out  1  status read returned bit0 = 1.
- timeout  out  1  MAX_POLLS exhausted.
- result_data  out  DATA_W  last captured status response.
- poll_count  out  16  polls issued, saturating.
- elapsed_cycles  out  32  see Optional Feature.

Behaviour:
- Reset (rst = 0, async): state IDLE; all outputs 0; table contents undefined.
- Table writes are accepted only in IDLE or DONE; tbl_wr_en ignored while busy; tbl_wr_idx >= NUM_CFG ignored.
- States: IDLE, WRITE, WAIT, POLL_REQ, POLL_RESP, DONE.
- IDLE/DONE + start:
  - Latch num_cfg (clamped to NUM_CFG) and poll_addr.
  - Clear done, pass, timeout, poll_count, result_data.
  - busy = 1 the next cycle.
  - Go to WRITE, or to WAIT if num_cfg == 0.
  - start while busy is ignored.
- WRITE:
  - One registered request per cycle: valid = 1, isWrite = 1, addr/data from entry i.
  - i runs 0..num_cfg-1 with no gaps; after the last entry, go to WAIT.
  - Req outputs return to 0 in any cycle with no request.
- WAIT: counter counts POLL_INTERVAL cycles, then POLL_REQ.
- POLL_REQ:
  - One cycle: valid = 1, isWrite = 0, addr = poll_addr, data = 0.
  - poll_count++ (saturating at 16'hFFFF); go to POLL_RESP with the counter reset.
- POLL_RESP:
  - On softreg_resp_valid: result_data <= resp_data.
    - If resp_data[0] == 1: go to DONE with pass = 1.
    - Else: failed poll.
  - If POLL_INTERVAL cycles elapse with no response: failed poll.
  - Failed poll: if poll_count == MAX_POLLS, go to DONE with timeout = 1; else go to WAIT.
- softreg_resp_valid outside POLL_RESP is ignored.
- DONE: busy = 0, done = 1; pass/timeout/result_data held until the next start.
- pass and timeout are never both 1.
- Latency: first write request is 1 cycle after start. The first poll request occurs num_cfg + POLL_INTERVAL + 1 cycles after start.

Optional Feature:
- Macro SEQ_CYCLE_COUNT_EN.
- Defined:
  - elapsed_cycles clears on accepted start and increments every cycle while busy, saturating at 32'hFFFFFFFF.
  - It holds its value in DONE.
- Undefined: elapsed_cycles is tied to 0 and no counter logic is generated.

Test Plan:
- Load 8 entries (addr = 0..7, data = 1001, 1001, 0, 16064, 24072, 32080, 10, 0); num_cfg = 8; start -> 8 consecutive write strobes with matching addr/data, starting 1 cycle after start.
- POLL_INTERVAL = 4, responder returns 0, 0, then 1 -> poll_count = 3, pass = 1, done = 1, result_data = 1, timeout = 0.
- MAX_POLLS = 3, responder always returns 0 -> timeout = 1, pass = 0, poll_count = 3.
- Responder never answers -> each poll ends after POLL_INTERVAL cycles; timeout after MAX_POLLS polls.
- num_cfg = 0 -> no write strobes; first poll read at cycle POLL_INTERVAL + 1 after start.
- Assert rst low mid-WRITE -> all outputs 0 immediately. tbl_wr_en while busy leaves the table unchanged. start in DONE restarts with cleared flags. With SEQ_CYCLE_COUNT_EN defined, elapsed_cycles equals the busy duration.
